// File: rtl/mem_line_arbiter_pkg.sv
// Shared types for the cache-line arbiter: line/word widths, FSM state and operation enums.
package mem_line_arbiter_pkg;

    localparam int LC3B_WORD_W = 16;
    localparam int LC3B_LINE_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_RD = 1'b0,
        ARB_WR = 1'b1
    } arb_op_t;

    // Index width for a channel count; never below one bit.
    function automatic int ptr_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_line_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward from ptr+1, wrapping at NUM_CH.
module mem_line_arbiter_rr_picker
    import mem_line_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    localparam int PW = ptr_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [PW-1:0]     grant,
    output logic              valid
);

    localparam logic [PW:0] NUM_CH_W = (PW+1)'(NUM_CH);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= NUM_CH_W) begin
                sum = sum - NUM_CH_W;
            end
            idx = sum[PW-1:0];
            if (req[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// N-channel round-robin arbiter multiplexing cache-line requesters onto one downstream line port.
// Optional per-channel performance counters are built when MEM_ARB_PERF_EN is defined.
//
//   state   | meaning
//   IDLE    | waiting for a request; picks and latches the next grant
//   BUSY    | downstream transaction in flight from latched request
//   RELEASE | one-cycle gap so the finished requester can drop its request
module mem_line_arbiter
    import mem_line_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = LC3B_WORD_W,
    parameter int LINE_W = LC3B_LINE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [LINE_W-1:0]        ch_rdata,
    output logic [NUM_CH-1:0]        ch_resp,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_resp
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NUM_CH*32-1:0]     perf_grant_cnt,
    output logic [NUM_CH*32-1:0]     perf_wait_cnt
`endif
);

    localparam int PW = ptr_w(NUM_CH);

    arb_state_t        state;
    arb_op_t           op;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic [NUM_CH-1:0] req;
    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;
    logic              sel_write;

    assign req = ch_read | ch_write;

    mem_line_arbiter_rr_picker #(.NUM_CH(NUM_CH)) u_picker (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pick_idx == PW'(i)) begin
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
                sel_write = ch_write[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op      <= ARB_RD;
            ptr     <= PW'(NUM_CH-1);
            grant   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant   <= pick_idx;
                        ptr     <= pick_idx;
                        op      <= sel_write ? ARB_WR : ARB_RD;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_resp) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_read  = (state == BUSY) && (op == ARB_RD);
    assign mem_write = (state == BUSY) && (op == ARB_WR);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ch_rdata  = mem_rdata;

    always_comb begin
        ch_resp = '0;
        if ((state == BUSY) && mem_resp) begin
            ch_resp[grant] = 1'b1;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] grant_cnt [NUM_CH];
    logic [31:0] wait_cnt  [NUM_CH];

    // Waiting means requesting while not the channel currently being served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                grant_cnt[i] <= '0;
                wait_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((state == IDLE) && pick_valid && (pick_idx == PW'(i)) && (grant_cnt[i] != '1)) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
                if (req[i] && !((state == BUSY) && (grant == PW'(i))) && (wait_cnt[i] != '1)) begin
                    wait_cnt[i] <= wait_cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_perf
        assign perf_grant_cnt[g*32 +: 32] = grant_cnt[g];
        assign perf_wait_cnt[g*32 +: 32]  = wait_cnt[g];
    end
`endif

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Scoreboard bench for mem_line_arbiter with four channels and a latency-programmable memory responder.
module tb_mem_line_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int LW  = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    ch_read, ch_write;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*LW-1:0] ch_wdata;
    logic [LW-1:0]     ch_rdata;
    logic [NCH-1:0]    ch_resp;
    logic              mem_read, mem_write;
    logic [AW-1:0]     mem_addr;
    logic [LW-1:0]     mem_wdata, mem_rdata;
    logic              mem_resp;
`ifdef MEM_ARB_PERF_EN
    logic [NCH*32-1:0] perf_grant_cnt, perf_wait_cnt;
`endif

    mem_line_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_read   (ch_read),
        .ch_write  (ch_write),
        .ch_addr   (ch_addr),
        .ch_wdata  (ch_wdata),
        .ch_rdata  (ch_rdata),
        .ch_resp   (ch_resp),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_grant_cnt (perf_grant_cnt),
        .perf_wait_cnt  (perf_wait_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [NCH-1:0] resp;
        logic [LW-1:0]  rdata;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int resp_cnt [NCH];
    int resp_total = 0;
    int last_resp_cyc = 0;
    int resp_delay = 1;
    bit resp_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] mem_data(logic [AW-1:0] a);
        if (a == 16'h4560) return 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_BEEF;
        return {8{a ^ 16'h5A5A}};
    endfunction

    always_comb mem_rdata = mem_data(mem_addr);

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory responder: mem_resp asserted resp_delay cycles after the strobe first appears.
    initial begin
        int cnt;
        cnt = 0;
        mem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if ((mem_read || mem_write) && resp_en) begin
                if (cnt == resp_delay) begin
                    mem_resp = 1'b1;
                    cnt = 0;
                end else begin
                    mem_resp = 1'b0;
                    cnt++;
                end
            end else begin
                mem_resp = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new downstream strobe and each completion pulse.
    initial begin
        bit   prev_strobe;
        bit   strobe;
        int   gap;
        req_t e;
        rsp_t r;
        prev_strobe = 1'b0;
        gap = 0;
        for (int i = 0; i < NCH; i++) resp_cnt[i] = 0;
        forever begin
            @(negedge clk);
            strobe = mem_read | mem_write;
            if (rst) begin
                prev_strobe = 1'b0;
                gap = 0;
            end else begin
                if (gap > 0) begin
                    check("release_gap_strobe", LW'(strobe), '0);
                    gap--;
                end
                if (strobe && !prev_strobe) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_request: addr %h with empty queue", mem_addr);
                    end else begin
                        e = req_q.pop_front();
                        check("mem_addr", LW'(mem_addr), LW'(e.addr));
                        check("mem_op", LW'({mem_read, mem_write}), e.wr ? LW'(2'b01) : LW'(2'b10));
                        if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
                    end
                end
                if (ch_resp != '0) begin
                    for (int i = 0; i < NCH; i++) if (ch_resp[i]) resp_cnt[i]++;
                    resp_total++;
                    last_resp_cyc = cyc;
                    gap = 2;
                    if (rsp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_resp: ch_resp %b with empty queue", ch_resp);
                    end else begin
                        r = rsp_q.pop_front();
                        check("ch_resp", LW'(ch_resp), LW'(r.resp));
                        check("ch_rdata", ch_rdata, r.rdata);
                    end
                end
                prev_strobe = strobe;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        ch_read[ch]             = rd;
        ch_write[ch]            = wr;
        ch_addr[ch*AW +: AW]    = a;
        ch_wdata[ch*LW +: LW]   = d;
    endtask

    task automatic push(input int ch, input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] d);
        req_q.push_back(req_t'{a, wr, d});
        rsp_q.push_back(rsp_t'{NCH'(1) << ch, mem_data(a)});
    endtask

    // Waits for every channel in mask to complete, dropping each request in its release cycle.
    task automatic serve(input logic [NCH-1:0] mask, input int budget);
        int start [NCH];
        logic [NCH-1:0] pend;
        int n;
        for (int i = 0; i < NCH; i++) start[i] = resp_cnt[i];
        pend = mask;
        n = 0;
        while (pend != '0 && n < budget) begin
            tick(1);
            n++;
            for (int i = 0; i < NCH; i++) begin
                if (pend[i] && resp_cnt[i] != start[i]) begin
                    pend[i] = 1'b0;
                    ch_read[i] = 1'b0;
                    ch_write[i] = 1'b0;
                end
            end
        end
        if (pend != '0) begin
            checks++;
            $display("FAIL serve_timeout: pending %b expected 0000", pend);
        end
    endtask

    task automatic wait_strobe(input string name, input int budget);
        int n;
        n = 0;
        while (!(mem_read || mem_write) && n < budget) begin
            tick(1);
            n++;
        end
        if (!(mem_read || mem_write)) begin
            checks++;
            $display("FAIL %s_timeout: no strobe within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s0, n;
`ifdef MEM_ARB_PERF_EN
        logic [31:0] g0, g1, w1;
`endif
        rst = 1'b1;
        ch_read = '0;
        ch_write = '0;
        ch_addr = '0;
        ch_wdata = '0;

        @(negedge clk);
        check("rst_mem_read", LW'(mem_read), '0);
        check("rst_mem_write", LW'(mem_write), '0);
        check("rst_ch_resp", LW'(ch_resp), '0);
        check("rst_mem_addr", LW'(mem_addr), '0);
        check("rst_mem_wdata", mem_wdata, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1);

        // Reset while a read is in flight.
        resp_en = 1'b0;
        req_q.push_back(req_t'{16'h1230, 1'b0, '0});
        drive(0, 1, 0, 16'h1230, '0);
        wait_strobe("rst_busy", 10);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_mem_read", LW'(mem_read), '0);
        check("midrst_mem_addr", LW'(mem_addr), '0);
        drive(0, 0, 0, '0, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        resp_en = 1'b1;
        resp_delay = 1;
        push(0, 0, 16'h1240, '0);
        push(1, 0, 16'h1250, '0);
        drive(0, 1, 0, 16'h1240, '0);
        drive(1, 1, 0, 16'h1250, '0);
        serve(4'b0011, 40);
        tick(2);

        // Single read, response three cycles after the strobe.
        resp_delay = 3;
        req_q.push_back(req_t'{16'h4560, 1'b0, '0});
        rsp_q.push_back(rsp_t'{4'b0010, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_BEEF});
        drive(1, 1, 0, 16'h4560, '0);
        serve(4'b0010, 20);
        tick(2);

        // Write withdrawn during BUSY completes with latched data.
        push(0, 1, 16'h3000, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        drive(0, 0, 1, 16'h3000, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        wait_strobe("withdraw", 10);
        drive(0, 0, 0, 16'hFFFF, '1);
        serve(4'b0001, 20);
        tick(2);

        // Back-to-back re-request of the same channel.
        resp_delay = 1;
        push(0, 0, 16'h4000, '0);
        drive(0, 1, 0, 16'h4000, '0);
        s0 = resp_cnt[0];
        n = 0;
        while (resp_cnt[0] == s0 && n < 20) begin
            tick(1);
            n++;
        end
        push(0, 0, 16'h4010, '0);
        drive(0, 1, 0, 16'h4010, '0);
        wait_strobe("b2b", 10);
        check("b2b_latency", LW'(cyc - last_resp_cyc), LW'(3));
        serve(4'b0001, 20);
        tick(2);

        // Park the pointer on channel 3 so contention starts at channel 0.
        push(3, 0, 16'h5000, '0);
        drive(3, 1, 0, 16'h5000, '0);
        serve(4'b1000, 20);
        tick(2);

        // Four channels writing continuously: grants 0,1,2,3,0.
        for (int i = 0; i < NCH; i++)
            drive(i, 0, 1, 16'h2000 + AW'(i * 16), {4{32'hC0DE_0000 + 32'(i)}});
        for (int k = 0; k < 5; k++) begin
            int c;
            c = k % NCH;
            push(c, 1, 16'h2000 + AW'(c * 16), {4{32'hC0DE_0000 + 32'(c)}});
        end
        s0 = resp_total;
        n = 0;
        while (resp_total - s0 < 5 && n < 60) begin
            tick(1);
            n++;
        end
        if (resp_total - s0 < 5) begin
            checks++;
            $display("FAIL contention_timeout: %0d responses expected 5", resp_total - s0);
        end
        ch_read = '0;
        ch_write = '0;
        tick(3);

        push(3, 0, 16'h5010, '0);
        drive(3, 1, 0, 16'h5010, '0);
        serve(4'b1000, 20);
        tick(3);

`ifdef MEM_ARB_PERF_EN
        // Channel 1 waits five cycles behind channel 0.
        g0 = perf_grant_cnt[0 +: 32];
        g1 = perf_grant_cnt[32 +: 32];
        w1 = perf_wait_cnt[32 +: 32];
        resp_delay = 1;
        push(0, 0, 16'h6000, '0);
        push(1, 0, 16'h6010, '0);
        drive(0, 1, 0, 16'h6000, '0);
        drive(1, 1, 0, 16'h6010, '0);
        serve(4'b0011, 40);
        tick(2);
        check("perf_wait1", LW'(perf_wait_cnt[32 +: 32] - w1), LW'(5));
        check("perf_grant0", LW'(perf_grant_cnt[0 +: 32] - g0), LW'(1));
        check("perf_grant1", LW'(perf_grant_cnt[32 +: 32] - g1), LW'(1));
`endif

        tick(3);
        check("req_q_drained", LW'(req_q.size()), '0);
        check("rsp_q_drained", LW'(rsp_q.size()), '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
